rx_logic_2: RTL and testbench

- Receive-side counterpart of the tx arbiter.
- Collects flits from up to 5 rx transceivers. Each transceiver uses a 2-phase (toggle) req/ack handshake with bundled data.
- Arbitrates round-robin among pending ports, pushes one flit per grant into the local input fifo, then toggles the ack back to the granted port.
- Sits between the 5 link receivers of a router port group and that router's input fifo.

---
 rtl/rx_logic_2.sv | 83 ++++++++
 tb/tb_rx_logic_2.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rx_logic_2.sv
// Receive-side arbiter: collects 2-phase req/ack flits from 5 link receivers and
// writes them one at a time, round-robin, into the router's input fifo.
module rx_logic_2 #(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned PORTS = 5,
    parameter int          ID    = -1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            push_req,
    input  logic [5*SIZE-1:0]     push_data,
    output logic [4:0]            push_ack,
    output logic                  fifo_write,
    input  logic                  fifo_full,
    output logic [SIZE-1:0]       fifo_item_in
);

    // The round-robin arithmetic below is hard-wired for five ports.
    if (PORTS != 5) begin : g_ports_check
        $error("rx_logic_2 (id %0d): PORTS must be 5", ID);
    end

    typedef enum logic [0:0] {StIdle, StWrite} state_t;

    state_t      state;
    logic [2:0]  last_grant;
    logic [4:0]  pending;
    logic        grant_valid;
    logic [2:0]  grant_idx;
    logic [3:0]  cand;

    // Search starts just after the last winner and wraps 4 -> 0.
    always_comb begin
        pending     = push_req ^ push_ack;
        grant_valid = 1'b0;
        grant_idx   = 3'd0;
        cand        = 4'd0;
        for (int i = 1; i <= 5; i++) begin
            cand = {1'b0, last_grant} + 4'(i);
            if (cand >= 4'd5) begin
                cand = cand - 4'd5;
            end
            if (!grant_valid && pending[cand[2:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[2:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= StIdle;
            last_grant   <= 3'd4;
            push_ack     <= 5'b00000;
            fifo_write   <= 1'b0;
            fifo_item_in <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (grant_valid && !fifo_full) begin
                        fifo_item_in        <= push_data[grant_idx*SIZE +: SIZE];
                        fifo_write          <= 1'b1;
                        push_ack[grant_idx] <= ~push_ack[grant_idx];
                        last_grant          <= grant_idx;
                        state               <= StWrite;
                    end else begin
                        fifo_write <= 1'b0;
                    end
                end
                // Idle cycle lets the fifo update fifo_full before the next decision.
                StWrite: begin
                    fifo_write <= 1'b0;
                    state      <= StIdle;
                end
                default: begin
                    fifo_write <= 1'b0;
                    state      <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_logic_2.sv
// Self-checking bench for rx_logic_2: directed scenarios plus random traffic against
// a transaction-level model of the round-robin receiver.
module tb_rx_logic_2;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  req;
    logic [39:0] data;
    logic        full;
    logic [4:0]  push_ack;
    logic        fifo_write;
    logic [7:0]  fifo_item_in;

    int total = 0;
    int bad   = 0;

    // Model state: acks the bench has seen granted, last winner, last written item.
    logic [4:0]  m_ack;
    int          m_rr;
    bit          m_wrote;
    logic [7:0]  m_item;
    int          grant_q[$];

    rx_logic_2 #(.SIZE(8), .PORTS(5), .ID(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .push_req     (req),
        .push_data    (data),
        .push_ack     (push_ack),
        .fifo_write   (fifo_write),
        .fifo_full    (full),
        .fifo_item_in (fifo_item_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ack   = 5'b00000;
        m_rr    = 4;
        m_wrote = 1'b0;
        m_item  = 8'h00;
    endtask

    // One clock: model decides a grant from what the bench is driving, then checks.
    task automatic step();
        logic [4:0] pend;
        int         g;
        @(posedge clk);
        pend = req ^ m_ack;
        g    = -1;
        if (!m_wrote && !full) begin
            for (int k = 1; k <= 5; k++) begin
                if (g < 0 && pend[(m_rr + k) % 5]) g = (m_rr + k) % 5;
            end
        end
        if (g >= 0) begin
            m_item   = data[g*8 +: 8];
            m_ack[g] = ~m_ack[g];
            m_rr     = g;
            grant_q.push_back(g);
        end
        m_wrote = (g >= 0);
        #1;
        check("fifo_write", {39'b0, fifo_write}, {39'b0, m_wrote});
        check("push_ack", {35'b0, push_ack}, {35'b0, m_ack});
        check("fifo_item_in", {32'b0, fifo_item_in}, {32'b0, m_item});
    endtask

    task automatic send(input int port, input logic [7:0] value);
        req[port]            = ~req[port];
        data[port*8 +: 8]    = value;
    endtask

    // Transmitters are reset together with the block.
    task automatic apply_reset();
        reset = 1'b1;
        req   = 5'b00000;
        model_reset();
        #1;
        check("rst_fifo_write", {39'b0, fifo_write}, 40'd0);
        check("rst_push_ack", {35'b0, push_ack}, 40'd0);
        check("rst_item", {32'b0, fifo_item_in}, 40'd0);
        @(negedge clk);
        reset = 1'b0;
        grant_q.delete();
    endtask

    initial begin
        int exp_fair[6];
        reset = 1'b1;
        req   = 5'b00000;
        data  = '0;
        full  = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Single port, 0->1 phase.
        send(2, 8'hA5);
        step();
        check("single_item", {32'b0, fifo_item_in}, 40'hA5);
        check("single_ack2", {39'b0, push_ack[2]}, 40'd1);
        step();
        check("single_write_drop", {39'b0, fifo_write}, 40'd0);

        // All five pending from a fresh pointer: strict port order, every other cycle.
        apply_reset();
        for (int k = 0; k < 5; k++) send(k, 8'h10 + 8'(k));
        repeat (10) step();
        check("all5_count", 40'(grant_q.size()), 40'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < grant_q.size()) check("all5_order", 40'(grant_q[k]), 40'(k));
        end
        check("all5_acks", {35'b0, push_ack}, 40'h1F);

        // Reset during the write cycle, then port 0 beats port 4.
        send(1, 8'h55);
        step();
        apply_reset();
        send(0, 8'h01);
        send(4, 8'h04);
        step();
        check("tie_winner", 40'(grant_q[grant_q.size()-1]), 40'd0);
        step();
        step();

        // Fairness: ports 1, 3 and 4 kept continuously pending.
        apply_reset();
        send(1, 8'h21);
        send(3, 8'h23);
        send(4, 8'h24);
        for (int c = 0; c < 12; c++) begin
            int n;
            n = grant_q.size();
            step();
            if (grant_q.size() > n) begin
                send(grant_q[n], 8'($urandom));
            end
        end
        exp_fair = '{1, 3, 4, 1, 3, 4};
        check("fair_count", 40'(grant_q.size()), 40'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < grant_q.size()) check("fair_order", 40'(grant_q[k]), 40'(exp_fair[k]));
        end

        // Back-pressure, then the 1->0 handshake phase on port 0.
        apply_reset();
        full = 1'b1;
        send(0, 8'h77);
        repeat (6) step();
        check("bp_ack0", {39'b0, push_ack[0]}, 40'd0);
        full = 1'b0;
        step();
        check("bp_release", {39'b0, fifo_write}, 40'd1);
        step();
        send(0, 8'h3C);
        step();
        check("phase2_ack0", {39'b0, push_ack[0]}, 40'd0);
        check("phase2_item", {32'b0, fifo_item_in}, 40'h3C);
        step();

        // Random traffic with random back-pressure.
        for (int c = 0; c < 400; c++) begin
            full = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 5; k++) begin
                if (req[k] == m_ack[k] && $urandom_range(0, 2) == 0) send(k, 8'($urandom));
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
